// File: rtl/ex_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_pipe_reg
// Brief    : EX/MEM pipeline register with cond-move write gating, stall,
//            flush and a saturating squashed-move counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  ExValid,
    input  logic [DATA_W-1:0]     AluResult,
    input  logic [DATA_W-1:0]     RtData,
    input  logic [REG_ADDR_W-1:0] DestReg,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemToReg,
    input  logic                  MovEn,
    input  logic                  MovWe,
    output logic                  MemValid,
    output logic [DATA_W-1:0]     MemAluResult,
    output logic [DATA_W-1:0]     MemRtData,
    output logic [REG_ADDR_W-1:0] MemDestReg,
    output logic                  MemRegWrite,
    output logic                  MemMemRead,
    output logic                  MemMemWrite,
    output logic                  MemMemToReg,
    output logic                  FwdValid,
    output logic [CNT_W-1:0]      SquashCnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic                  r_valid;
    logic [DATA_W-1:0]     r_alu_result;
    logic [DATA_W-1:0]     r_rt_data;
    logic [REG_ADDR_W-1:0] r_dest_reg;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_mem_to_reg;
    logic [CNT_W-1:0]      r_squash_cnt;

    logic w_we;
    logic w_squash;

    // $zero is never a real destination, so it is excluded from the write here.
    assign w_we     = ExValid & RegWrite & (~MovEn | MovWe) & (DestReg != '0);
    assign w_squash = ExValid & MovEn & RegWrite & ~MovWe;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_rt_data    <= '0;
            r_dest_reg   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_squash_cnt <= '0;
        end else if (Flush) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_rt_data    <= '0;
            r_dest_reg   <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!Stall) begin
            // An invalid EX slot loads the same bubble a flush would.
            r_valid      <= ExValid;
            r_alu_result <= ExValid ? AluResult : '0;
            r_rt_data    <= ExValid ? RtData : '0;
            r_dest_reg   <= ExValid ? DestReg : '0;
            r_reg_write  <= w_we;
            r_mem_read   <= ExValid & MemRead;
            r_mem_write  <= ExValid & MemWrite;
            r_mem_to_reg <= ExValid & MemToReg;
            if (w_squash && (r_squash_cnt != c_cnt_max)) begin
                r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

    assign MemValid     = r_valid;
    assign MemAluResult = r_alu_result;
    assign MemRtData    = r_rt_data;
    assign MemDestReg   = r_dest_reg;
    assign MemRegWrite  = r_reg_write;
    assign MemMemRead   = r_mem_read;
    assign MemMemWrite  = r_mem_write;
    assign MemMemToReg  = r_mem_to_reg;
    assign FwdValid     = r_valid & r_reg_write & (r_dest_reg != '0);
    assign SquashCnt    = r_squash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_pipe_reg
// Brief    : Randomized self-checking bench for ex_mem_pipe_reg against a
//            behavioural model; a second instance uses a 2-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe_reg;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, ExValid;
    logic [31:0] AluResult, RtData;
    logic [4:0]  DestReg;
    logic        RegWrite, MemRead, MemWrite, MemToReg, MovEn, MovWe;

    logic        MemValid, MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg, FwdValid;
    logic [31:0] MemAluResult, MemRtData;
    logic [4:0]  MemDestReg;
    logic [15:0] SquashCnt;

    logic        s_valid, s_rw, s_mr, s_mw, s_mtr, s_fwd;
    logic [31:0] s_alu, s_rt;
    logic [4:0]  s_dest;
    logic [1:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic        m_valid, m_rw, m_mr, m_mw, m_mtr;
    logic [31:0] m_alu, m_rt;
    logic [4:0]  m_dest;
    int          m_cnt, m_cnt2;

    always #5 Clk = ~Clk;

    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .ExValid(ExValid),
        .AluResult(AluResult), .RtData(RtData), .DestReg(DestReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .MovEn(MovEn), .MovWe(MovWe),
        .MemValid(MemValid), .MemAluResult(MemAluResult), .MemRtData(MemRtData),
        .MemDestReg(MemDestReg), .MemRegWrite(MemRegWrite), .MemMemRead(MemMemRead),
        .MemMemWrite(MemMemWrite), .MemMemToReg(MemMemToReg), .FwdValid(FwdValid),
        .SquashCnt(SquashCnt)
    );

    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) dut_small (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .ExValid(ExValid),
        .AluResult(AluResult), .RtData(RtData), .DestReg(DestReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .MovEn(MovEn), .MovWe(MovWe),
        .MemValid(s_valid), .MemAluResult(s_alu), .MemRtData(s_rt),
        .MemDestReg(s_dest), .MemRegWrite(s_rw), .MemMemRead(s_mr),
        .MemMemWrite(s_mw), .MemMemToReg(s_mtr), .FwdValid(s_fwd),
        .SquashCnt(s_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs present at the rising edge.
    task automatic model_edge();
        if (!Rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_mtr} = '0;
            m_alu = '0; m_rt = '0; m_dest = '0;
            m_cnt = 0; m_cnt2 = 0;
        end else if (Flush) begin
            {m_valid, m_rw, m_mr, m_mw, m_mtr} = '0;
            m_alu = '0; m_rt = '0; m_dest = '0;
        end else if (!Stall) begin
            if (ExValid) begin
                m_valid = 1'b1;
                m_alu   = AluResult;
                m_rt    = RtData;
                m_dest  = DestReg;
                m_rw    = RegWrite && (!MovEn || MovWe) && (DestReg != 0);
                m_mr    = MemRead;
                m_mw    = MemWrite;
                m_mtr   = MemToReg;
                if (MovEn && RegWrite && !MovWe) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else begin
                {m_valid, m_rw, m_mr, m_mw, m_mtr} = '0;
                m_alu = '0; m_rt = '0; m_dest = '0;
            end
        end
    endtask

    task automatic compare_all();
        check("MemValid",     MemValid,     m_valid);
        check("MemAluResult", MemAluResult, m_alu);
        check("MemRtData",    MemRtData,    m_rt);
        check("MemDestReg",   MemDestReg,   m_dest);
        check("MemRegWrite",  MemRegWrite,  m_rw);
        check("MemMemRead",   MemMemRead,   m_mr);
        check("MemMemWrite",  MemMemWrite,  m_mw);
        check("MemMemToReg",  MemMemToReg,  m_mtr);
        check("FwdValid",     FwdValid,     m_valid && m_rw && (m_dest != 0));
        check("SquashCnt",    SquashCnt,    m_cnt);
        check("SquashCnt2",   s_cnt,        m_cnt2);
        check("SmallRegWrite", s_rw,        m_rw);
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic ev, input logic [31:0] alu, input logic [31:0] rt,
                          input logic [4:0] dst, input logic rw, input logic mr,
                          input logic mw, input logic mtr, input logic me, input logic mwe);
        ExValid = ev; AluResult = alu; RtData = rt; DestReg = dst;
        RegWrite = rw; MemRead = mr; MemWrite = mw; MemToReg = mtr;
        MovEn = me; MovWe = mwe;
    endtask

    task automatic rand_in();
        set_in(($urandom_range(0, 3) != 0), $urandom, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 2) == 0), 1'($urandom));
    endtask

    initial begin
        Stall = 1'b0; Flush = 1'b0;

        // Reset with non-zero inputs
        Rst = 1'b0;
        set_in(1, 32'hDEAD_BEEF, 32'h5555_AAAA, 5'd7, 1, 1, 1, 1, 1, 0);
        step();
        check("reset_valid_lit", MemValid, 0);
        check("reset_cnt_lit", SquashCnt, 0);
        check("reset_alu_lit", MemAluResult, 0);

        // Plain ALU op
        @(negedge Clk);
        Rst = 1'b1;
        set_in(1, 32'h1234, 32'h0, 5'd8, 1, 0, 0, 0, 0, 0);
        step();
        check("alu_rw_lit", MemRegWrite, 1);
        check("alu_res_lit", MemAluResult, 32'h1234);
        check("alu_fwd_lit", FwdValid, 1);

        // movz squash, then condition met
        @(negedge Clk);
        set_in(1, 32'h99, 32'h0, 5'd9, 1, 0, 0, 0, 1, 0);
        step();
        check("squash_valid_lit", MemValid, 1);
        check("squash_rw_lit", MemRegWrite, 0);
        check("squash_fwd_lit", FwdValid, 0);
        check("squash_cnt_lit", SquashCnt, 1);
        @(negedge Clk);
        MovWe = 1'b1;
        step();
        check("move_rw_lit", MemRegWrite, 1);
        check("move_cnt_lit", SquashCnt, 1);

        // Stall three cycles with changing inputs, then Stall+Flush
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            Stall = 1'b1;
            rand_in();
            MovEn = 1'b1; MovWe = 1'b0; RegWrite = 1'b1; ExValid = 1'b1;
            step();
            check("stall_alu_lit", MemAluResult, 32'h99);
            check("stall_cnt_lit", SquashCnt, 1);
        end
        @(negedge Clk);
        Flush = 1'b1;
        MemWrite = 1'b1;
        step();
        check("flush_valid_lit", MemValid, 0);
        check("flush_mw_lit", MemMemWrite, 0);
        check("flush_cnt_lit", SquashCnt, 1);

        // Store to $zero
        @(negedge Clk);
        Stall = 1'b0; Flush = 1'b0;
        set_in(1, 32'h40, 32'hCAFE_F00D, 5'd0, 1, 0, 1, 0, 0, 0);
        step();
        check("store_mw_lit", MemMemWrite, 1);
        check("store_rw_lit", MemRegWrite, 0);
        check("store_rt_lit", MemRtData, 32'hCAFE_F00D);

        // 2-bit counter saturation from reset
        @(negedge Clk);
        Rst = 1'b0;
        step();
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1, 32'h0, 32'h0, 5'd3, 1, 0, 0, 0, 1, 0);
            step();
            check("small_sat_lit", s_cnt, (i < 3) ? i + 1 : 3);
            @(negedge Clk);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Rst   = ($urandom_range(0, 99) != 0);
            Flush = ($urandom_range(0, 9) == 0);
            Stall = ($urandom_range(0, 4) == 0);
            rand_in();
            step();
            @(negedge Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
